sdm_manchester_tx: RTL and testbench
====================================

// Module: sdm_manchester_tx
// PURPOSE
//  Digital 2nd-order sigma-delta modulator with Manchester line encoder; transmit side of the SDFM mode-2 input.
//  Converts signed parallel samples into a 1-bit stream; emits MOUT = BIT ^ CLKOUT, so SDFM decodes it with SDCLK tied 0.
//  Sits in the modulator / loopback path and drives one DSDIN lane of an SDFM instance.
// PARAMETERS
//  DW   16  sample width (signed two's complement); FS = 2^(DW-1)
//  DIV  4   EXTCLK cycles per half bit; bit rate = f(EXTCLK)/(2*DIV); DIV >= 2
// PORTS
//  EXTCLK    in   1     single clock; all logic on rising edge
//  EXTRST    in   1     synchronous reset, active-high
//  EN        in   1     modulator enable
//  IN_DATA   in   DW    signed sample
//  IN_VALID  in   1     IN_DATA valid
//  IN_READY  out  1     holding register free; IN_READY = !pending
//  CLR_SAT   in   1     clears SAT
//  CLKOUT    out  1     bit clock: 0 in first half bit, 1 in second
//  BITOUT    out  1     raw modulator bit
//  MOUT      out  1     Manchester line = BITOUT ^ CLKOUT (1 -> "10", 0 -> "01")
//  SAT       out  1     sticky integrator-saturation flag
// BEHAVIOUR
//  Reset: CLKOUT, BITOUT, MOUT, SAT = 0; IN_READY = 1; cnt, phase, i1, i2, x, pending = 0.
//  Reset takes priority over every other input, including mid-bit; the next bit after reset starts at phase 0.
//  Sample path: 1-entry holding reg. Accept when IN_VALID && IN_READY; pending <= 1.
//    At the next bit boundary: x <= clamp(hold, -3FS/4, +3FS/4) and pending <= 0.
//    The value -3FS/4 is -24576 for DW=16. x is then held until a newer sample arrives.
//  Simultaneous accept and boundary: the boundary uses the current x; the new sample applies at the following boundary.
//  Timing: cnt counts 0..DIV-1. At cnt==DIV-1, phase toggles and cnt <= 0.
//    A bit boundary is the transition phase 1 -> 0, and the first cycle after EN rises.
//  At a bit boundary, in this order:
//    b   = (i2 >= 0)
//    fb  = b ? +FS : -FS
//    i1' = sat(i1 + x - fb)
//    i2' = sat(i2 + i1' - fb)
//    BITOUT <= b
//  Widths: i1 is DW+3 bits signed and i2 is DW+5 bits signed. sat() clips to the type range; any clip sets SAT.
//  SAT holds until CLR_SAT; if set and clear coincide, set wins.
//  Output timing: CLKOUT <= phase; MOUT <= b ^ phase. All outputs registered.
//    The first bit is visible one cycle after the first EN=1 cycle. Each half bit lasts exactly DIV cycles.
//  EN = 0: cnt, phase, i1, i2 cleared next cycle; CLKOUT, BITOUT, MOUT forced 0.
//    Holding reg, x and SAT retained; handshake stays live.
//  EN dropped mid-bit: the bit is truncated, and the restart begins at a fresh boundary with zeroed integrators.
//  No underflow condition: with no new sample, x repeats indefinitely.
// TESTING
//  1 x=0, DIV=4, EN=1 -> BITOUT repeats 1,0,0,1.
//    MOUT per half-bit: 1,0, 0,1, 0,1, 1,0. Each level lasts 4 EXTCLK cycles. SAT=0.
//  2 x=+16384 held for 1024 bits -> ones count 768 +/-2.
//    x=-16384 held for 1024 bits -> ones count 256 +/-2. SAT=0.
//  3 IN_DATA=32767 -> clamped to 24576; ones in 1024 bits = 896 +/-2; SAT=0.
//    IN_DATA=-32768 -> 128 +/-2.
//  4 IN_VALID held 1 with 3 distinct samples -> IN_READY drops after each accept and rises the cycle after each boundary.
//    Exactly one sample is consumed per boundary, in order; a sample accepted in a boundary cycle applies one bit later.
//  5 EXTRST=1 mid-second-half -> next cycle all outputs 0 and IN_READY=1.
//    After release with EN=1 -> sequence restarts 1,0,0,1. EN=0 for 3 cycles -> same restart, but x is kept.
//  6 Loopback: MOUT -> SDFM DSDIN in mode 2 (SDCLK=0), sinc3 OSR 64 -> decoded DC matches x within 1%.

Source files
------------

// File: rtl/sdm_manchester_tx.sv
`default_nettype none
// ============================================================================
// Module   : sdm_manchester_tx
// Purpose  : 2nd-order sigma-delta modulator with Manchester line encoder
//            (MOUT = BITOUT ^ CLKOUT), one-entry sample holding register.
// Revision : 1.0 - initial release
// ============================================================================
module sdm_manchester_tx #(
    parameter int DW  = 16,
    parameter int DIV = 4
) (
    input  logic          EXTCLK,
    input  logic          EXTRST,
    input  logic          EN,
    input  logic [DW-1:0] IN_DATA,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic          CLR_SAT,
    output logic          CLKOUT,
    output logic          BITOUT,
    output logic          MOUT,
    output logic          SAT
);

    localparam int I1W = DW + 3;
    localparam int I2W = DW + 5;
    localparam int AW  = DW + 7;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic signed [AW-1:0] c_FS     = AW'(2**(DW-1));
    localparam logic signed [AW-1:0] c_I1_MAX = AW'(2**(I1W-1) - 1);
    localparam logic signed [AW-1:0] c_I1_MIN = -AW'(2**(I1W-1));
    localparam logic signed [AW-1:0] c_I2_MAX = AW'(2**(I2W-1) - 1);
    localparam logic signed [AW-1:0] c_I2_MIN = -AW'(2**(I2W-1));
    localparam logic signed [DW-1:0] c_XMAX   = DW'(3 * 2**(DW-1) / 4);
    localparam logic signed [DW-1:0] c_XMIN   = -c_XMAX;
    localparam logic [CW-1:0]        c_CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0]          r_cnt;
    logic                   r_phase;
    logic                   r_en_d;
    logic                   r_pending;
    logic signed [DW-1:0]   r_hold;
    logic signed [DW-1:0]   r_x;
    logic signed [I1W-1:0]  r_i1;
    logic signed [I2W-1:0]  r_i2;

    logic                   w_boundary;
    logic                   w_b;
    logic signed [AW-1:0]   w_fb;
    logic signed [AW-1:0]   w_i1_sum;
    logic signed [AW-1:0]   w_i1_new;
    logic signed [AW-1:0]   w_i2_sum;
    logic signed [I2W-1:0]  w_i2_new;
    logic                   w_sat_ev;
    logic signed [DW-1:0]   w_x_new;

    assign IN_READY = ~r_pending;

    always_comb begin
        // A bit starts on the first enabled cycle and whenever phase wraps 1 -> 0
        w_boundary = EN && (!r_en_d || ((r_cnt == c_CNT_LAST) && r_phase));
        w_b        = ~r_i2[I2W-1];
        w_fb       = w_b ? c_FS : -c_FS;
        w_sat_ev   = 1'b0;

        w_i1_sum = AW'(r_i1) + AW'(r_x) - w_fb;
        w_i1_new = w_i1_sum;
        if (w_i1_sum > c_I1_MAX) begin
            w_i1_new = c_I1_MAX;
            w_sat_ev = 1'b1;
        end else if (w_i1_sum < c_I1_MIN) begin
            w_i1_new = c_I1_MIN;
            w_sat_ev = 1'b1;
        end

        w_i2_sum = AW'(r_i2) + w_i1_new - w_fb;
        w_i2_new = w_i2_sum[I2W-1:0];
        if (w_i2_sum > c_I2_MAX) begin
            w_i2_new = c_I2_MAX[I2W-1:0];
            w_sat_ev = 1'b1;
        end else if (w_i2_sum < c_I2_MIN) begin
            w_i2_new = c_I2_MIN[I2W-1:0];
            w_sat_ev = 1'b1;
        end

        w_x_new = r_hold;
        if (r_hold > c_XMAX) begin
            w_x_new = c_XMAX;
        end else if (r_hold < c_XMIN) begin
            w_x_new = c_XMIN;
        end
    end

    always_ff @(posedge EXTCLK) begin
        if (EXTRST) begin
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_en_d    <= 1'b0;
            r_pending <= 1'b0;
            r_hold    <= '0;
            r_x       <= '0;
            r_i1      <= '0;
            r_i2      <= '0;
            CLKOUT    <= 1'b0;
            BITOUT    <= 1'b0;
            MOUT      <= 1'b0;
            SAT       <= 1'b0;
        end else begin
            // Accept only when empty, so this never collides with the boundary clear
            if (IN_VALID && !r_pending) begin
                r_hold    <= IN_DATA;
                r_pending <= 1'b1;
            end

            if (EN) begin
                r_en_d <= 1'b1;
                if (w_boundary) begin
                    r_cnt   <= '0;
                    r_phase <= 1'b0;
                    r_i1    <= w_i1_new[I1W-1:0];
                    r_i2    <= w_i2_new;
                    BITOUT  <= w_b;
                    CLKOUT  <= 1'b0;
                    MOUT    <= w_b;
                    if (r_pending) begin
                        r_x       <= w_x_new;
                        r_pending <= 1'b0;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                    CLKOUT  <= ~r_phase;
                    MOUT    <= BITOUT ^ ~r_phase;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_en_d  <= 1'b0;
                r_cnt   <= '0;
                r_phase <= 1'b0;
                r_i1    <= '0;
                r_i2    <= '0;
                CLKOUT  <= 1'b0;
                BITOUT  <= 1'b0;
                MOUT    <= 1'b0;
            end

            SAT <= (w_boundary & w_sat_ev) | (SAT & ~CLR_SAT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdm_manchester_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdm_manchester_tx
// Purpose  : Self-checking bench for sdm_manchester_tx against a bit-level
//            reference model of the modulator and handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdm_manchester_tx;

    localparam int    DW  = 16;
    localparam int    DIV = 4;
    localparam longint FS = 64'sd1 << (DW - 1);

    logic          EXTCLK = 1'b0;
    logic          EXTRST = 1'b1;
    logic          EN = 1'b0;
    logic [DW-1:0] IN_DATA = '0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic          CLR_SAT = 1'b0;
    logic          CLKOUT;
    logic          BITOUT;
    logic          MOUT;
    logic          SAT;

    int total = 0;
    int bad   = 0;

    // Reference model: e counts consecutive enabled cycles; a bit starts every 2*DIV of them
    longint m_i1, m_i2, m_x, m_hold;
    bit     m_pend, m_sat, m_bit, m_clk, m_mout;
    int     m_e;

    sdm_manchester_tx #(.DW(DW), .DIV(DIV)) u_dut (
        .EXTCLK   (EXTCLK),
        .EXTRST   (EXTRST),
        .EN       (EN),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .CLR_SAT  (CLR_SAT),
        .CLKOUT   (CLKOUT),
        .BITOUT   (BITOUT),
        .MOUT     (MOUT),
        .SAT      (SAT)
    );

    always #5 EXTCLK = ~EXTCLK;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        longint fb, t, lim1, lim2;
        bit     b, ev, acc;
        if (EXTRST) begin
            m_i1 = 0; m_i2 = 0; m_x = 0; m_hold = 0;
            m_pend = 0; m_sat = 0; m_bit = 0; m_clk = 0; m_mout = 0; m_e = 0;
            return;
        end
        ev  = 0;
        acc = IN_VALID && !m_pend;
        if (EN) begin
            if (m_e % (2 * DIV) == 0) begin
                lim1 = 64'sd1 << (DW + 2);
                lim2 = 64'sd1 << (DW + 4);
                b  = (m_i2 >= 0);
                fb = b ? FS : -FS;
                t  = m_i1 + m_x - fb;
                if (t > lim1 - 1) begin t = lim1 - 1; ev = 1; end
                if (t < -lim1)    begin t = -lim1;    ev = 1; end
                m_i1 = t;
                t  = m_i2 + m_i1 - fb;
                if (t > lim2 - 1) begin t = lim2 - 1; ev = 1; end
                if (t < -lim2)    begin t = -lim2;    ev = 1; end
                m_i2  = t;
                m_bit = b;
                if (m_pend) begin
                    m_x = m_hold;
                    if (m_x > 3 * FS / 4)  m_x = 3 * FS / 4;
                    if (m_x < -3 * FS / 4) m_x = -3 * FS / 4;
                    m_pend = 0;
                end
            end
            m_clk  = ((m_e % (2 * DIV)) >= DIV);
            m_mout = m_bit ^ m_clk;
            m_e++;
        end else begin
            m_e = 0; m_i1 = 0; m_i2 = 0;
            m_bit = 0; m_clk = 0; m_mout = 0;
        end
        if (acc) begin
            m_hold = longint'($signed(IN_DATA));
            m_pend = 1;
        end
        m_sat = ev | (m_sat & !CLR_SAT);
    endtask

    task automatic cyc();
        model_step();
        @(posedge EXTCLK);
        #1;
        chk("clkout",   CLKOUT,   m_clk);
        chk("bitout",   BITOUT,   m_bit);
        chk("mout",     MOUT,     m_mout);
        chk("in_ready", IN_READY, !m_pend);
        chk("sat",      SAT,      m_sat);
    endtask

    task automatic do_reset();
        EXTRST = 1'b1;
        cyc();
        EXTRST = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] v);
        IN_DATA  = v;
        IN_VALID = 1'b1;
        cyc();
        IN_VALID = 1'b0;
    endtask

    task automatic dc_run(input string tag, input logic [DW-1:0] v, input int lo, input int hi);
        int ones;
        EN = 1'b0;
        do_reset();
        load(v);
        EN = 1'b1;
        repeat (4 * DIV) cyc();
        EN = 1'b0;
        repeat (2) cyc();
        EN = 1'b1;
        ones = 0;
        for (int k = 0; k < 1024; k++) begin
            cyc();
            ones += int'(BITOUT);
            repeat (2 * DIV - 1) cyc();
        end
        if (ones < lo || ones > hi)
            $display("%s ones=%0d outside %0d..%0d", tag, ones, lo, hi);
        chk(tag, longint'(ones >= lo && ones <= hi), 1);
        chk({tag, "_sat"}, SAT, 0);
    endtask

    initial begin
        bit pat[4];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

        // Reset state
        repeat (2) cyc();
        chk("rst_clkout", CLKOUT, 0);
        chk("rst_bitout", BITOUT, 0);
        chk("rst_mout",   MOUT,   0);
        chk("rst_ready",  IN_READY, 1);
        chk("rst_sat",    SAT,    0);
        EXTRST = 1'b0;

        // Zero input: bits 1,0,0,1 repeating, each half bit DIV cycles
        EN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("t1_bit",   BITOUT, pat[k % 4]);
            chk("t1_mout0", MOUT,   pat[k % 4]);
            repeat (DIV - 1) cyc();
            cyc();
            chk("t1_mout1", MOUT, !pat[k % 4]);
            chk("t1_clk1",  CLKOUT, 1);
            repeat (DIV - 1) cyc();
        end

        // Reset in the middle of a second half bit, then restart pattern
        repeat (DIV + 2) cyc();
        EXTRST = 1'b1;
        cyc();
        chk("t5_clkout", CLKOUT, 0);
        chk("t5_mout",   MOUT,   0);
        chk("t5_ready",  IN_READY, 1);
        EXTRST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t5_bit", BITOUT, pat[k]);
            repeat (2 * DIV - 1) cyc();
        end

        // Held valid with distinct samples, then EN drop keeps x
        IN_VALID = 1'b1;
        for (int s = 0; s < 3; s++) begin
            IN_DATA = DW'(1000 * (s + 1));
            repeat (2 * DIV) cyc();
        end
        IN_VALID = 1'b0;
        repeat (6 * DIV) cyc();
        EN = 1'b0;
        repeat (3) cyc();
        EN = 1'b1;
        repeat (8 * DIV) cyc();

        // DC density, including clamped full-scale inputs
        dc_run("dc_pos_half", 16'sd16384,  766, 770);
        dc_run("dc_neg_half", -16'sd16384, 254, 258);
        dc_run("dc_pos_full", 16'sd32767,  894, 898);
        dc_run("dc_neg_full", 16'h8000,    126, 130);

        // Random traffic: handshake, enable drops, resets, sat clears
        EN = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            IN_VALID = ($urandom_range(0, 2) == 0);
            IN_DATA  = DW'($urandom);
            CLR_SAT  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 150) == 0) EN = ~EN;
            EXTRST   = ($urandom_range(0, 700) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
